// File: rtl/cpu_run_pkg.sv
// Shared state encoding and default parameters for the CPU run sequencer.
package cpu_run_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        DONE,
        TOUT
    } run_state_e;

    localparam int START_CYCLES_DEF = 2;
    localparam int TIMEOUT_DEF      = 4096;
    localparam int CW_DEF           = 16;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Request/result bundle between the host side and the run sequencer.
interface cpu_run_ctrl_if
    import cpu_run_pkg::*;
#(
    parameter int CW = CW_DEF
);
    logic          go;
    logic          cpu_done;
    logic          cpu_start;
    logic          busy;
    logic          finished;
    logic          timed_out;
    logic [CW-1:0] cycle_count;
    logic [7:0]    runs_ok;

    modport master (
        output go, cpu_done,
        input  cpu_start, busy, finished, timed_out, cycle_count, runs_ok
    );

    modport slave (
        input  go, cpu_done,
        output cpu_start, busy, finished, timed_out, cycle_count, runs_ok
    );
endinterface

// File: rtl/run_cycle_counter.sv
// Up-counter with synchronous clear, enable and a terminal-count compare.
module run_cycle_counter
    import cpu_run_pkg::*;
#(
    parameter int            CW     = CW_DEF,
    parameter logic [CW-1:0] TC_VAL = '1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == TC_VAL);
endmodule

// File: rtl/cpu_run_ctrl.sv
// Run sequencer: parks the CPU in reset, releases it, times the run and flags timeouts.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int START_CYCLES = START_CYCLES_DEF,
    parameter int CW           = CW_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    cpu_run_ctrl_if.slave  bus
);
    localparam int            SW      = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SW-1:0] SC_LOAD = SW'(START_CYCLES - 1);
    localparam logic [CW-1:0] TC_VAL  = CW'(TIMEOUT - 1);

    run_state_e    r_state, w_next;
    logic [SW-1:0] r_sc, w_sc_next;
    logic [7:0]    r_runs, w_runs_next;
    logic          r_cpu_start, r_busy, r_finished, r_timed_out;
    logic          w_clr, w_en, w_tc;
    logic [CW-1:0] w_count;

    run_cycle_counter #(
        .CW     (CW),
        .TC_VAL (TC_VAL)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_count (w_count),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_next      = r_state;
        w_sc_next   = r_sc;
        w_runs_next = r_runs;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        case (r_state)
            IDLE, DONE, TOUT: begin
                if (bus.go) begin
                    w_next    = START;
                    w_sc_next = SC_LOAD;
                    w_clr     = 1'b1;
                end
            end
            // cpu_done is deliberately not looked at here: it may be left over from the previous program
            START: begin
                if (r_sc == '0) begin
                    w_next = RUN;
                end else begin
                    w_sc_next = r_sc - 1'b1;
                end
            end
            RUN: begin
                if (bus.cpu_done) begin
                    w_next      = DONE;
                    w_runs_next = r_runs + 8'd1;
                end else if (w_tc) begin
                    w_next = TOUT;
                end else begin
                    w_en = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Flags are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_sc        <= '0;
            r_runs      <= '0;
            r_cpu_start <= 1'b1;
            r_busy      <= 1'b0;
            r_finished  <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_sc        <= w_sc_next;
            r_runs      <= w_runs_next;
            r_cpu_start <= (w_next != RUN);
            r_busy      <= (w_next == START) || (w_next == RUN);
            r_finished  <= (w_next == DONE);
            r_timed_out <= (w_next == TOUT);
        end
    end

    assign bus.cpu_start   = r_cpu_start;
    assign bus.busy        = r_busy;
    assign bus.finished    = r_finished;
    assign bus.timed_out   = r_timed_out;
    assign bus.cycle_count = w_count;
    assign bus.runs_ok     = r_runs;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: two instances (long and short timeout) against a run-level reference model.
module tb_cpu_run_ctrl;
    localparam int SC    = 2;
    localparam int CW    = 16;
    localparam int A_TMO = 4096;
    localparam int B_TMO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic r_go = 1'b0;
    logic r_done = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.CW(CW)) ifa ();
    cpu_run_ctrl_if #(.CW(CW)) ifb ();

    assign ifa.go       = r_go;
    assign ifa.cpu_done = r_done;
    assign ifb.go       = r_go;
    assign ifb.cpu_done = r_done;

    cpu_run_ctrl #(.START_CYCLES(SC), .CW(CW), .TIMEOUT(A_TMO)) u_dut_a (
        .clk(clk), .reset_n(rst_n), .bus(ifa.slave));
    cpu_run_ctrl #(.START_CYCLES(SC), .CW(CW), .TIMEOUT(B_TMO)) u_dut_b (
        .clk(clk), .reset_n(rst_n), .bus(ifb.slave));

    // Model: a run is "elapsed cycles since go was accepted"; the first SC of them are parked.
    typedef struct packed {
        bit busy;
        int el;
        int cnt;
        int runs;
        bit fin;
        bit to;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_step(mdl_t m, bit g, bit d, int tmo);
        mdl_t n = m;
        int   j;
        if (!m.busy) begin
            if (g) begin
                n.busy = 1'b1; n.el = 0; n.cnt = 0; n.fin = 1'b0; n.to = 1'b0;
            end
        end else if (m.el < SC) begin
            n.el = m.el + 1;
        end else begin
            j = m.el - SC;
            if (d) begin
                n.busy = 1'b0; n.fin = 1'b1; n.cnt = j; n.runs = (m.runs + 1) % 256;
            end else if (j == tmo - 1) begin
                n.busy = 1'b0; n.to = 1'b1; n.cnt = j;
            end else begin
                n.el = m.el + 1; n.cnt = j + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= mdl_step(ma, r_go, r_done, A_TMO);
            mb <= mdl_step(mb, r_go, r_done, B_TMO);
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("a_cpu_start", ifa.cpu_start, !(ma.busy && ma.el >= SC));
        chk("a_busy",      ifa.busy,      ma.busy);
        chk("a_finished",  ifa.finished,  ma.fin);
        chk("a_timed_out", ifa.timed_out, ma.to);
        chk("a_count",     ifa.cycle_count, ma.cnt);
        chk("a_runs",      ifa.runs_ok,   ma.runs);
        chk("b_cpu_start", ifb.cpu_start, !(mb.busy && mb.el >= SC));
        chk("b_busy",      ifb.busy,      mb.busy);
        chk("b_finished",  ifb.finished,  mb.fin);
        chk("b_timed_out", ifb.timed_out, mb.to);
        chk("b_count",     ifb.cycle_count, mb.cnt);
        chk("b_runs",      ifb.runs_ok,   mb.runs);
    end

    // Pulse go for one cycle, then stop at the first RUN cycle of instance A.
    task automatic go_and_wait(output int n_hi, output bit ok);
        r_go = 1'b1;
        @(negedge clk);
        r_go = 1'b0;
        n_hi = 0;
        ok   = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (!ifa.cpu_start) ok = 1'b1;
            else begin
                if (ifa.busy) n_hi++;
                @(negedge clk);
            end
        end
    endtask

    task automatic do_reset();
        r_go = 1'b0; r_done = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int   n_hi;
        bit   ok;
        int   saved;
        int   w;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_cpu_start", ifa.cpu_start, 1);
        chk("idle_busy",      ifa.busy, 0);
        chk("idle_count",     ifa.cycle_count, 0);
        chk("idle_runs",      ifa.runs_ok, 0);

        // Program that signals done 105 cycles after release.
        go_and_wait(n_hi, ok);
        chk("run105_release", ok, 1);
        chk("run105_start_len", n_hi, 2);
        repeat (105) @(negedge clk);
        r_done = 1'b1;
        @(negedge clk);
        r_done = 1'b0;
        chk("run105_finished", ifa.finished, 1);
        chk("run105_count",    ifa.cycle_count, 105);
        chk("run105_runs",     ifa.runs_ok, 1);

        // Stale done through START.
        r_done = 1'b1;
        go_and_wait(n_hi, ok);
        chk("stale_release", ok, 1);
        chk("stale_start_len", n_hi, 2);
        @(negedge clk);
        r_done = 1'b0;
        chk("stale_finished", ifa.finished, 1);
        chk("stale_count",    ifa.cycle_count, 0);
        chk("stale_b_finished", ifb.finished, 1);

        // Short-timeout instance: no done at all.
        saved = ifb.runs_ok;
        go_and_wait(n_hi, ok);
        chk("tout_release", ok, 1);
        repeat (15) @(negedge clk);
        chk("tout_b_busy_last", ifb.busy, 1);
        @(negedge clk);
        chk("tout_b_timed_out", ifb.timed_out, 1);
        chk("tout_b_count",     ifb.cycle_count, 15);
        chk("tout_b_runs",      ifb.runs_ok, saved);
        chk("tout_b_cpu_start", ifb.cpu_start, 1);
        r_done = 1'b1;
        @(negedge clk);
        r_done = 1'b0;

        // done in the last allowed RUN cycle wins over the timeout.
        go_and_wait(n_hi, ok);
        chk("edge_release", ok, 1);
        repeat (15) @(negedge clk);
        r_done = 1'b1;
        @(negedge clk);
        r_done = 1'b0;
        chk("edge_b_finished",  ifb.finished, 1);
        chk("edge_b_timed_out", ifb.timed_out, 0);
        chk("edge_b_count",     ifb.cycle_count, 15);
        chk("edge_b_runs",      ifb.runs_ok, saved + 1);

        // go pulses during RUN are ignored; go in DONE restarts with flags cleared.
        go_and_wait(n_hi, ok);
        chk("ign_release", ok, 1);
        repeat (4) begin
            r_go = 1'b1; @(negedge clk);
            r_go = 1'b0; @(negedge clk);
        end
        repeat (2) @(negedge clk);
        r_done = 1'b1;
        @(negedge clk);
        r_done = 1'b0;
        chk("ign_finished", ifa.finished, 1);
        chk("ign_count",    ifa.cycle_count, 10);
        r_go = 1'b1;
        @(negedge clk);
        r_go = 1'b0;
        chk("restart_busy",     ifa.busy, 1);
        chk("restart_finished", ifa.finished, 0);
        chk("restart_count",    ifa.cycle_count, 0);
        chk("restart_b_tout",   ifb.timed_out, 0);

        // Asynchronous reset in the middle of a run.
        for (int i = 0; i < 40 && ifa.cpu_start; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("midrst_precount", ifa.cycle_count, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cpu_start", ifa.cpu_start, 1);
        chk("midrst_busy",      ifa.busy, 0);
        chk("midrst_count",     ifa.cycle_count, 0);
        chk("midrst_runs",      ifa.runs_ok, 0);
        chk("midrst_finished",  ifa.finished, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        go_and_wait(n_hi, ok);
        chk("postrst_release", ok, 1);
        repeat (3) @(negedge clk);
        r_done = 1'b1;
        @(negedge clk);
        r_done = 1'b0;
        chk("postrst_count", ifa.cycle_count, 3);
        chk("postrst_runs",  ifa.runs_ok, 1);

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            r_go   = ($urandom_range(0, 7) == 0);
            r_done = ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        r_go = 1'b0;
        r_done = 1'b0;

        // 256 successful runs wrap runs_ok.
        do_reset();
        r_done = 1'b1;
        for (int k = 0; k < 256; k++) begin
            r_go = 1'b1;
            @(negedge clk);
            r_go = 1'b0;
            w = 0;
            while (!ifa.finished && w < 10) begin
                @(negedge clk);
                w++;
            end
            chk("wrap_run_done", ifa.finished, 1);
        end
        chk("wrap_a_runs", ifa.runs_ok, 0);
        chk("wrap_b_runs", ifb.runs_ok, 0);
        r_go = 1'b1;
        @(negedge clk);
        r_go = 1'b0;
        repeat (4) @(negedge clk);
        chk("wrap_plus1_runs", ifa.runs_ok, 1);
        r_done = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
        $fatal(1, "watchdog");
    end
endmodule
